// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   pipe_state_t : stage fill state (EMPTY / ONE / FULL)
//   pipe_occ_t   : occupancy count, 0..2
//   BUBBLE_BIT   : replicated to form an all-zero (NOP) control field
//   occ_of()     : maps a fill state to its occupancy count
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef logic [1:0] pipe_occ_t;

  localparam logic BUBBLE_BIT = 1'b0;

  function automatic pipe_occ_t occ_of(input pipe_state_t s);
    unique case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: valid flag plus control and data fields.
// Ports:
//   i_clk   : clock, rising edge
//   i_clear : synchronous clear; zeroes valid, ctrl and data (wins over load)
//   i_load  : capture i_ctrl/i_data and mark the entry valid
//   i_ctrl  : control field to capture
//   i_data  : data field to capture
//   o_valid : entry holds a live item
//   o_ctrl  : held control field (bubble when invalid)
//   o_data  : held data field
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= {CTRL_WIDTH{BUBBLE_BIT}};
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register between CPU stages, with flush-to-bubble.
// Build option: define PIPE_SKID_EN to add a skid entry S (FULL state) so that
// in_ready is a flop and the stage absorbs one extra item when downstream stalls.
// Without it, in_ready = !M_valid || out_ready and occupancy is 0 or 1.
// Ports:
//   i_clk       : clock, rising edge
//   i_clr       : synchronous active-high reset (wins over flush)
//   i_flush     : synchronous kill of all held entries; input in this cycle dropped
//   i_in_valid  : upstream entry valid
//   o_in_ready  : stage can accept this cycle
//   i_in_ctrl   : upstream control field
//   i_in_data   : upstream data field
//   o_out_valid : output entry valid
//   i_out_ready : downstream accepts this cycle
//   o_out_ctrl  : control field, zero when o_out_valid=0
//   o_out_data  : data field, zero after reset or flush
//   o_occupancy : number of held entries
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [CTRL_WIDTH-1:0] i_in_ctrl,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CTRL_WIDTH-1:0] o_out_ctrl,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output pipe_occ_t             o_occupancy
);

  pipe_state_t r_state;

  logic                  w_kill;
  logic                  w_accept;
  logic                  w_send;
  logic                  w_m_valid;
  logic                  w_m_load;
  logic                  w_m_clear;
  logic [CTRL_WIDTH-1:0] w_m_ctrl_nxt;
  logic [DATA_WIDTH-1:0] w_m_data_nxt;

`ifdef PIPE_SKID_EN
  logic                  w_s_valid;
  logic                  w_s_load;
  logic                  w_s_clear;
  logic                  w_m_from_s;
  logic [CTRL_WIDTH-1:0] w_s_ctrl;
  logic [DATA_WIDTH-1:0] w_s_data;

  // Ready depends only on the S flop: no out_ready -> in_ready path.
  assign o_in_ready   = ~w_s_valid;
  assign w_m_ctrl_nxt = w_m_from_s ? w_s_ctrl : i_in_ctrl;
  assign w_m_data_nxt = w_m_from_s ? w_s_data : i_in_data;
`else
  assign o_in_ready   = ~w_m_valid | i_out_ready;
  assign w_m_ctrl_nxt = i_in_ctrl;
  assign w_m_data_nxt = i_in_data;
`endif

  assign w_kill   = i_clr | i_flush;
  assign w_accept = i_in_valid & o_in_ready;
  assign w_send   = w_m_valid & i_out_ready;

  always_comb begin
    w_m_load  = 1'b0;
    w_m_clear = w_kill;
`ifdef PIPE_SKID_EN
    w_s_load   = 1'b0;
    w_s_clear  = w_kill;
    w_m_from_s = 1'b0;
`endif
    if (!w_kill) begin
      unique case (r_state)
        EMPTY: w_m_load = w_accept;
        ONE: begin
          if (w_send) begin
            // Drained with nothing behind it: return M to a bubble.
            if (w_accept) w_m_load = 1'b1;
            else          w_m_clear = 1'b1;
          end
`ifdef PIPE_SKID_EN
          else if (w_accept) begin
            w_s_load = 1'b1;
          end
`endif
        end
        FULL: begin
`ifdef PIPE_SKID_EN
          if (w_send) begin
            w_m_load   = 1'b1;
            w_m_from_s = 1'b1;
            w_s_clear  = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr || i_flush) begin
      r_state <= EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (w_accept) r_state <= ONE;
        ONE: begin
          if (w_send && !w_accept) r_state <= EMPTY;
`ifdef PIPE_SKID_EN
          else if (w_accept && !w_send) r_state <= FULL;
`endif
        end
        FULL:    if (w_send) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_entry_m (
    .i_clk  (i_clk),
    .i_clear(w_m_clear),
    .i_load (w_m_load),
    .i_ctrl (w_m_ctrl_nxt),
    .i_data (w_m_data_nxt),
    .o_valid(w_m_valid),
    .o_ctrl (o_out_ctrl),
    .o_data (o_out_data)
  );

`ifdef PIPE_SKID_EN
  pipe_entry_reg #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_entry_s (
    .i_clk  (i_clk),
    .i_clear(w_s_clear),
    .i_load (w_s_load),
    .i_ctrl (i_in_ctrl),
    .i_data (i_in_data),
    .o_valid(w_s_valid),
    .o_ctrl (w_s_ctrl),
    .o_data (w_s_data)
  );
`endif

  assign o_out_valid = w_m_valid;
  assign o_occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (both PIPE_SKID_EN builds).
module tb_pipe_stage_elastic;

  logic        clk;
  logic        clr;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_elastic #(
    .CTRL_WIDTH(16),
    .DATA_WIDTH(32)
  ) dut (
    .i_clk      (clk),
    .i_clr      (clr),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_ctrl  (in_ctrl),
    .i_in_data  (in_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_ctrl (out_ctrl),
    .o_out_data (out_data),
    .o_occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Apply inputs, check combinational in_ready before the edge, then clock once.
  task automatic step(input string tag, input logic iv, input logic [31:0] id,
                      input logic [15:0] ic, input logic ordy, input logic fl,
                      input logic cl, input logic er);
    in_valid  = iv;
    in_data   = id;
    in_ctrl   = ic;
    out_ready = ordy;
    flush     = fl;
    clr       = cl;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [15:0] ec,
                            input logic [31:0] ed, input logic [1:0] eo, input logic cd);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_ctrl"}, 32'(out_ctrl), 32'(ec));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(eo));
    if (cd) chk({tag, ".out_data"}, out_data, ed);
  endtask

  initial begin
    // Reset with a live handshake presented during clr.
    clr = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hEE; in_ctrl = 16'hEEEE;
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    expect_out("reset", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Streaming 1..8, one cycle latency.
    for (int k = 1; k <= 8; k++) begin
      step("stream", 1'b1, 32'(k), 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_out("stream", 1'b1, 16'h00A5, 32'(k), 2'd1, 1'b1);
    end
    step("drain", 1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("drain", 1'b0, 16'h0, 32'h0, 2'd0, 1'b0);

`ifdef PIPE_SKID_EN
    // Back-pressure: 3-cycle stall, S absorbs one entry.
    step("bp1", 1'b1, 32'd1, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp1", 1'b1, 16'h00A5, 32'd1, 2'd1, 1'b1);
    step("bp2", 1'b1, 32'd2, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("bp2", 1'b1, 16'h00A5, 32'd1, 2'd2, 1'b1);
    step("bp3", 1'b1, 32'd3, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("bp3", 1'b1, 16'h00A5, 32'd1, 2'd2, 1'b1);
    step("bp4", 1'b1, 32'd3, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("bp4", 1'b1, 16'h00A5, 32'd1, 2'd2, 1'b1);
    step("bp5", 1'b1, 32'd3, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("bp5", 1'b1, 16'h00A5, 32'd2, 2'd1, 1'b1);
    step("bp6", 1'b1, 32'd3, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp6", 1'b1, 16'h00A5, 32'd3, 2'd1, 1'b1);
    step("bp7", 1'b1, 32'd4, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp7", 1'b1, 16'h00A5, 32'd4, 2'd1, 1'b1);
    step("bp8", 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp8", 1'b0, 16'h0, 32'h0, 2'd0, 1'b0);

    // Flush while FULL with 5,6 and 7 offered.
    step("fl1", 1'b1, 32'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("fl1", 1'b1, 16'h1234, 32'd5, 2'd1, 1'b1);
    step("fl2", 1'b1, 32'd6, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("fl2", 1'b1, 16'h1234, 32'd5, 2'd2, 1'b1);
    step("fl3", 1'b1, 32'd7, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("fl3", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);
    chk("fl3.in_ready_after", 32'(in_ready), 32'd1);
`else
    // Back-pressure without skid: in_ready follows out_ready combinationally.
    step("bp1", 1'b1, 32'd1, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp1", 1'b1, 16'h00A5, 32'd1, 2'd1, 1'b1);
    step("bp2", 1'b1, 32'd2, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("bp2", 1'b1, 16'h00A5, 32'd1, 2'd1, 1'b1);
    step("bp3", 1'b1, 32'd2, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("bp3", 1'b1, 16'h00A5, 32'd1, 2'd1, 1'b1);
    step("bp4", 1'b1, 32'd2, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("bp4", 1'b1, 16'h00A5, 32'd1, 2'd1, 1'b1);
    step("bp5", 1'b1, 32'd2, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp5", 1'b1, 16'h00A5, 32'd2, 2'd1, 1'b1);
    step("bp6", 1'b1, 32'd3, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp6", 1'b1, 16'h00A5, 32'd3, 2'd1, 1'b1);
    step("bp7", 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("bp7", 1'b0, 16'h0, 32'h0, 2'd0, 1'b0);

    // Flush while holding 5 with 7 offered.
    step("fl1", 1'b1, 32'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("fl1", 1'b1, 16'h1234, 32'd5, 2'd1, 1'b1);
    step("fl2", 1'b1, 32'd7, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("fl2", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);
    chk("fl2.in_ready_after", 32'(in_ready), 32'd1);
`endif
    step("fl_idle", 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("fl_idle", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);

    // Flush while empty and ready: offered input is still discarded.
    step("fl_empty", 1'b1, 32'd8, 16'h00A5, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("fl_empty", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);

    // Flush in the same cycle as a send of entry 3.
    step("fs1", 1'b1, 32'd3, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("fs1", 1'b1, 16'h00A5, 32'd3, 2'd1, 1'b1);
    in_valid = 1'b1; in_data = 32'd4; out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("fs2.delivered_valid", 32'(out_valid), 32'd1);
    chk("fs2.delivered_data", out_data, 32'd3);
    step("fs2", 1'b1, 32'd4, 16'h00A5, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_out("fs2", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);
    step("fs3", 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("fs3", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);

    // Reset mid-operation, inputs offered during clr.
    step("rs1", 1'b1, 32'd9, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("rs1", 1'b1, 16'h00A5, 32'd9, 2'd1, 1'b1);
`ifdef PIPE_SKID_EN
    step("rs2", 1'b1, 32'd10, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("rs2", 1'b1, 16'h00A5, 32'd9, 2'd2, 1'b1);
    step("rs3", 1'b1, 32'd11, 16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    step("rs3", 1'b1, 32'd11, 16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    expect_out("rs3", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);
    // clr and flush together behave as clr alone.
    step("rs4", 1'b1, 32'd12, 16'h00A5, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_out("rs4", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);
    step("rs5", 1'b0, 32'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("rs5", 1'b0, 16'h0, 32'h0, 2'd0, 1'b1);

    // Normal operation resumes after reset.
    step("post", 1'b1, 32'h21, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("post", 1'b1, 16'h5A5A, 32'h21, 2'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Generic elastic pipeline register placed between CPU pipeline stages, e.g. decode→execute and execute→memory. It carries a control field and a data field with a valid/ready handshake. It supports flush-to-bubble, in which the control field is zeroed so the downstream stage sees a NOP, and optional skid buffering for full throughput with registered ready. It generalises the fixed-field, clear-only stage register: width-parametrised, and it adds back-pressure and stall handling.

## Interface
- CTRL_WIDTH, 16, control-field width; forced to 0 whenever the entry is invalid.
- DATA_WIDTH, 32, data-field width (operands, immediates, PC, register indices packed by the instantiating top level).
- clk  in  1  clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_WIDTH  upstream control field.
- in_data  in  DATA_WIDTH  upstream data field.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_WIDTH  control field; 0 when out_valid=0.
- out_data  out  DATA_WIDTH  data field; 0 after reset or flush.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Transfers: an accept occurs when in_valid && in_ready; a send occurs when out_valid && out_ready.
- Entries: main entry M drives the outputs; skid entry S exists only with skid enabled.
- States:
  - EMPTY (occupancy 0):
    - accept → M, go to ONE.
  - ONE (occupancy 1):
    - accept & send → M=in, stay in ONE.
    - accept & no send → S=in, go to FULL.
    - send only → go to EMPTY.
    - neither → hold.
  - FULL (occupancy 2):
    - send → M=S, clear S, go to ONE.
    - no accept is possible (in_ready=0).
- Priority is clr > flush > transfers.
- flush:
  - Next cycle: M and S are invalid, ctrl and data are zeroed, and occupancy is 0.
  - The input presented in the flush cycle is discarded even if in_ready=1.
  - A send in the flush cycle still counts as delivered. Downstream owns it and it is not retracted.
- Stall: while out_valid && !out_ready, out_ctrl and out_data stay bit-stable.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush or clr.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 from the first cycle after clr deasserts.
- Handshakes while clr=1 are ignored.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Skid enabled:
  - in_ready = !S_valid, taken directly from a flop.
  - No combinational path out_ready→in_ready.
  - No combinational path in_*→out_*.
- Skid disabled:
  - in_ready = !M_valid || out_ready (combinational).
  - Occupancy never exceeds 1.
- When flush and clr are asserted in the same cycle, the result is identical to clr alone.

## Configuration
- The macro is PIPE_SKID_EN.
- Defined: the S entry and the FULL state are built. in_ready is registered and the stage absorbs one extra entry after downstream stalls.
- Undefined: S and FULL are removed. in_ready is combinational from out_ready, occupancy is 0 or 1, and all other behaviour is identical.

## Structure
- The shared package pipe_pkg holds:
  - the state enum pipe_state_t {EMPTY, ONE, FULL};
  - the occupancy typedef pipe_occ_t (2 bits);
  - the bubble constant for a zero control field.
- Sub-module pipe_entry_reg holds valid, ctrl and data, with load and clear inputs.
  - It is instantiated once for M, and a second time for S under PIPE_SKID_EN.
  - The clear input zeroes ctrl and data.
- The top level holds the state register and handshake logic.

## Test plan
- Streaming:
  - Stimulus: clr for 2 cycles, then in_valid=1, out_ready=1, in_data=1..8, in_ctrl=0x00A5.
  - Required: out_data=1..8 on consecutive cycles, each one cycle after its accept; occupancy stays 1.
- Back-pressure (skid):
  - Stimulus: drop out_ready for 3 cycles while streaming.
  - Required: occupancy goes 1→2 and in_ready=0 for the remainder of the stall.
  - Required: out_data is held stable throughout.
  - Required: after out_ready returns, the outputs continue in order with no loss.
- Flush:
  - Stimulus: flush=1 while FULL holds entries 5 and 6 and in_valid=1 with entry 7.
  - Required next cycle: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
  - Required: entries 5, 6 and 7 never appear.
- Flush with send:
  - Stimulus: flush and out_ready both 1 in the same cycle while out_data=3.
  - Required: entry 3 is counted as delivered and nothing follows it.
- Reset mid-operation:
  - Stimulus: clr=1 while FULL, with in_valid=1 during clr.
  - Required: all outputs take their reset values the next cycle and the inputs presented during clr are never output.
- Build without PIPE_SKID_EN:
  - Stimulus: rerun the back-pressure scenario.
  - Required: occupancy never exceeds 1 and in_ready follows out_ready in the same cycle.
